// File: rtl/branch_sched_pkg.sv
// Shared encodings for the D-stage branch resolution controller:
// branch op codes, FSM states and the rt-operand usage lookup.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLEZ = 3'd2,
    BGTZ = 3'd3,
    BLTZ = 3'd4,
    BGEZ = 3'd5
  } br_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  // Bit n set when op code n compares against rt
  localparam logic [7:0] RT_OPS = 8'b0000_0011;

  function automatic logic uses_rt(input logic [2:0] op);
    return RT_OPS[op];
  endfunction

endpackage

// File: rtl/branch_sched_if.sv
// D-stage <-> branch controller <-> F-stage handshake bundle.
// master: decoder/forwarding side; slave: branch_sched.
interface branch_sched_if #(parameter int DW = 32);
  logic          flush;
  logic          req_valid;
  logic [2:0]    br_op;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic          rs_ready;
  logic          rt_ready;
  logic [DW-1:0] target;
  logic          req_ack;
  logic          stall;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;

  modport master (
    output flush, req_valid, br_op, rs_val, rt_val, rs_ready, rt_ready, target,
    input  req_ack, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  flush, req_valid, br_op, rs_val, rt_val, rs_ready, rt_ready, target,
    output req_ack, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_sched_br_cmp.sv
// Combinational operand comparator: equality, rs-zero and rs-sign flags.
module br_cmp #(parameter int DW = 32) (
  input  logic [DW-1:0] rs,
  input  logic [DW-1:0] rt,
  output logic          eq,
  output logic          eqz,
  output logic          ltz
);
  assign eq  = (rs == rt);
  assign eqz = (rs == '0);
  assign ltz = rs[DW-1];
endmodule

// File: rtl/branch_sched.sv
// Branch resolution FSM: waits for operands, acks, then pulses a redirect.
// Optional BRANCH_STAT_EN adds stat_total / stat_taken counters.
//
// state   | meaning
// IDLE    | no branch in flight
// WAIT    | branch present, operands not yet valid (front end stalled)
// RESOLVE | branch accepted last cycle, redirect presented this cycle
module branch_sched
  import branch_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  branch_sched_if.slave bus,
  output logic          busy
`ifdef BRANCH_STAT_EN
  ,
  output logic [DW-1:0] stat_total,
  output logic [DW-1:0] stat_taken
`endif
);

  state_t        state, state_nx;
  logic          ready, taken, ack, stall_c;
  logic          eq, eqz, ltz;
  logic          taken_q;
  logic [DW-1:0] target_q;

  br_cmp #(.DW(DW)) u_cmp (
    .rs  (bus.rs_val),
    .rt  (bus.rt_val),
    .eq  (eq),
    .eqz (eqz),
    .ltz (ltz)
  );

  assign ready = bus.rs_ready & (bus.rt_ready | ~uses_rt(bus.br_op));

  always_comb begin
    taken = 1'b0;
    case (bus.br_op)
      BEQ:     taken = eq;
      BNE:     taken = ~eq;
      BLEZ:    taken = ltz | eqz;
      BGTZ:    taken = ~ltz & ~eqz;
      BLTZ:    taken = ltz;
      BGEZ:    taken = ~ltz;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    ack      = 1'b0;
    stall_c  = 1'b0;
    if (bus.flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, RESOLVE: begin
          state_nx = IDLE;
          if (bus.req_valid) begin
            if (ready) begin
              ack      = 1'b1;
              state_nx = RESOLVE;
            end else begin
              stall_c  = 1'b1;
              state_nx = WAIT;
            end
          end
        end
        WAIT: begin
          if (!bus.req_valid) begin
            state_nx = IDLE;
          end else if (ready) begin
            ack      = 1'b1;
            state_nx = RESOLVE;
          end else begin
            stall_c  = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state   <= state_nx;
      taken_q <= ack & taken;
      if (ack) target_q <= bus.target;
    end
  end

  // Combinational outputs are held low while reset is asserted
  assign bus.req_ack        = ack & reset;
  assign bus.stall          = stall_c & reset;
  assign bus.redirect_valid = taken_q & ~bus.flush;
  assign bus.redirect_pc    = target_q;
  assign busy               = (state != IDLE);

`ifdef BRANCH_STAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_total <= '0;
      stat_taken <= '0;
    end else begin
      if (bus.req_ack)        stat_total <= stat_total + DW'(1);
      if (bus.redirect_valid) stat_taken <= stat_taken + DW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_sched.sv
// Directed bench for branch_sched: single-branch vector table plus
// wait, abandon, back-to-back, reset and flush sequences.
module tb_branch_sched;

  logic        clk;
  logic        reset;
  logic        busy;
  int          checks = 0;
  int          errors = 0;
`ifdef BRANCH_STAT_EN
  logic [31:0] stat_total, stat_taken;
`endif

  branch_sched_if #(.DW(32)) bus();

  branch_sched #(.DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
`ifdef BRANCH_STAT_EN
    ,
    .stat_total (stat_total),
    .stat_taken (stat_taken)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        rt_rdy;
    logic [31:0] tgt;
    logic        taken;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic rs_rdy, input logic rt_rdy, input logic [31:0] tgt);
    bus.req_valid = 1'b1;
    bus.br_op     = op;
    bus.rs_val    = rs;
    bus.rt_val    = rt;
    bus.rs_ready  = rs_rdy;
    bus.rt_ready  = rt_rdy;
    bus.target    = tgt;
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_1234, 32'h0000_1234, 1'b1, 32'h0000_1000, 1'b1};
    vecs[1]  = '{3'd1, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_1010, 1'b0};
    vecs[2]  = '{3'd3, 32'h8000_0000, 32'h0,         1'b0, 32'h0000_1020, 1'b0};
    vecs[3]  = '{3'd2, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_1030, 1'b1};
    vecs[4]  = '{3'd5, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_1040, 1'b1};
    vecs[5]  = '{3'd4, 32'hFFFF_FFFF, 32'h0,         1'b0, 32'h0000_1050, 1'b1};
    vecs[6]  = '{3'd0, 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_1060, 1'b0};
    vecs[7]  = '{3'd1, 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_1070, 1'b1};
    vecs[8]  = '{3'd3, 32'h0000_0001, 32'h0,         1'b0, 32'h0000_1080, 1'b1};
    vecs[9]  = '{3'd2, 32'h7FFF_FFFF, 32'h0,         1'b0, 32'h0000_1090, 1'b0};
    vecs[10] = '{3'd5, 32'h8000_0000, 32'h0,         1'b0, 32'h0000_10A0, 1'b0};
    vecs[11] = '{3'd4, 32'h7FFF_FFFF, 32'h0,         1'b0, 32'h0000_10B0, 1'b0};
    vecs[12] = '{3'd6, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_10C0, 1'b0};
    vecs[13] = '{3'd7, 32'hFFFF_FFFF, 32'h0,         1'b0, 32'h0000_10D0, 1'b0};

    reset         = 1'b0;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b1;
    bus.br_op     = 3'd0;
    bus.rs_val    = '0;
    bus.rt_val    = '0;
    bus.rs_ready  = 1'b0;
    bus.rt_ready  = 1'b0;
    bus.target    = '0;
    #2;
    check("reset stall", bus.stall, 0);
    check("reset ack", bus.req_ack, 0);
    check("reset redirect_valid", bus.redirect_valid, 0);
    check("reset redirect_pc", bus.redirect_pc, 0);
    check("reset busy", busy, 0);
`ifdef BRANCH_STAT_EN
    check("reset stat_total", stat_total, 0);
    check("reset stat_taken", stat_taken, 0);
`endif
    bus.req_valid = 1'b0;
    mid();
    reset = 1'b1;
    next_cycle();

    // single branches, operands ready
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b1, vecs[i].rt_rdy, vecs[i].tgt);
      mid();
      check($sformatf("vec%0d ack", i), bus.req_ack, 1);
      check($sformatf("vec%0d stall", i), bus.stall, 0);
      check($sformatf("vec%0d early redirect", i), bus.redirect_valid, 0);
      next_cycle();
      bus.req_valid = 1'b0;
      mid();
      check($sformatf("vec%0d redirect_valid", i), bus.redirect_valid, vecs[i].taken);
      if (vecs[i].taken)
        check($sformatf("vec%0d redirect_pc", i), bus.redirect_pc, vecs[i].tgt);
      check($sformatf("vec%0d busy", i), busy, 1);
      next_cycle();
      mid();
      check($sformatf("vec%0d pulse end", i), bus.redirect_valid, 0);
      check($sformatf("vec%0d idle", i), busy, 0);
      next_cycle();
    end

    // BEQ waiting 3 cycles on rt; final rt value decides
    drive(3'd0, 32'd7, 32'd3, 1'b1, 1'b0, 32'h0000_2000);
    for (int c = 0; c < 3; c++) begin
      bus.rt_val = (c == 1) ? 32'd7 : 32'd3;
      mid();
      check($sformatf("wait c%0d stall", c), bus.stall, 1);
      check($sformatf("wait c%0d ack", c), bus.req_ack, 0);
      check($sformatf("wait c%0d busy", c), busy, (c > 0));
      next_cycle();
    end
    bus.rt_val   = 32'd7;
    bus.rt_ready = 1'b1;
    mid();
    check("wait ack", bus.req_ack, 1);
    check("wait ack stall", bus.stall, 0);
    next_cycle();
    bus.req_valid = 1'b0;
    mid();
    check("wait redirect_valid", bus.redirect_valid, 1);
    check("wait redirect_pc", bus.redirect_pc, 32'h0000_2000);
    next_cycle();
    mid();
    check("wait pulse end", bus.redirect_valid, 0);
    next_cycle();

    // request withdrawn while waiting
    drive(3'd1, 32'd1, 32'd2, 1'b0, 1'b1, 32'h0000_2100);
    mid();
    check("abandon stall", bus.stall, 1);
    next_cycle();
    bus.req_valid = 1'b0;
    mid();
    check("abandon ack", bus.req_ack, 0);
    check("abandon busy", busy, 1);
    next_cycle();
    mid();
    check("abandon idle", busy, 0);
    check("abandon redirect", bus.redirect_valid, 0);
    next_cycle();

    // back-to-back BGEZ then BLTZ
    drive(3'd5, 32'd5, 32'd0, 1'b1, 1'b0, 32'h0000_3000);
    mid();
    check("b2b ack0", bus.req_ack, 1);
    next_cycle();
    drive(3'd4, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 32'h0000_3100);
    mid();
    check("b2b ack1", bus.req_ack, 1);
    check("b2b stall1", bus.stall, 0);
    check("b2b redirect0", bus.redirect_valid, 1);
    check("b2b pc0", bus.redirect_pc, 32'h0000_3000);
    next_cycle();
    bus.req_valid = 1'b0;
    mid();
    check("b2b redirect1", bus.redirect_valid, 1);
    check("b2b pc1", bus.redirect_pc, 32'h0000_3100);
    next_cycle();
    mid();
    check("b2b pulse end", bus.redirect_valid, 0);
    check("b2b idle", busy, 0);
    next_cycle();

    // async reset in RESOLVE
    drive(3'd0, 32'd9, 32'd9, 1'b1, 1'b1, 32'h0000_4000);
    mid();
    check("rstres ack", bus.req_ack, 1);
    next_cycle();
    bus.req_valid = 1'b0;
    check("rstres redirect before", bus.redirect_valid, 1);
    reset = 1'b0;
    #1;
    check("rstres redirect", bus.redirect_valid, 0);
    check("rstres pc", bus.redirect_pc, 0);
    check("rstres busy", busy, 0);
    mid();
    reset = 1'b1;
    next_cycle();
    mid();
    check("rstres after redirect", bus.redirect_valid, 0);
    check("rstres after busy", busy, 0);
    next_cycle();

    // async reset in WAIT
    drive(3'd0, 32'd9, 32'd9, 1'b1, 1'b0, 32'h0000_4100);
    mid();
    check("rstwait stall0", bus.stall, 1);
    next_cycle();
    mid();
    check("rstwait stall1", bus.stall, 1);
    check("rstwait busy1", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("rstwait stall", bus.stall, 0);
    check("rstwait busy", busy, 0);
    check("rstwait redirect", bus.redirect_valid, 0);
    bus.req_valid = 1'b0;
    next_cycle();
    next_cycle();
    mid();
    reset = 1'b1;
    next_cycle();
    mid();
    check("rstwait after busy", busy, 0);
    check("rstwait after redirect", bus.redirect_valid, 0);
    check("rstwait after stall", bus.stall, 0);
`ifdef BRANCH_STAT_EN
    check("rstwait stat_total", stat_total, 0);
    check("rstwait stat_taken", stat_taken, 0);
`endif
    next_cycle();

    // flush in RESOLVE of a taken BEQ
    drive(3'd0, 32'd9, 32'd9, 1'b1, 1'b1, 32'h0000_5000);
    mid();
    check("flush ack", bus.req_ack, 1);
    next_cycle();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b1;
    mid();
    check("flush redirect", bus.redirect_valid, 0);
    next_cycle();
    bus.flush = 1'b0;
    mid();
    check("flush busy", busy, 0);
    check("flush redirect after", bus.redirect_valid, 0);
`ifdef BRANCH_STAT_EN
    check("flush stat_total", stat_total, 1);
    check("flush stat_taken", stat_taken, 0);
`endif
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_sched.md
# branch_sched

D-stage branch resolution controller that sequences the equality/zero/sign comparator for conditional branches. It waits until forwarded operands are valid and stalls the front end meanwhile. It then registers the comparison and issues a one-cycle redirect to the fetch stage. It sits between the D-stage decoder/forwarding muxes and the F-stage next-PC logic.

## Interface
- `DW`, 32: operand and PC width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `flush`  in  1  synchronous kill (exception/eret); drops any pending branch.
- `req_valid`  in  1  D stage holds a conditional branch.
- `br_op`  in  3  branch kind: BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ.
- `rs_val`, `rt_val`  in  DW  forwarded operands.
- `rs_ready`, `rt_ready`  in  1  operand valid (no pending producer).
- `target`  in  DW  branch target PC.
- `req_ack`  out  1  branch accepted this cycle; D may advance.
- `stall`  out  1  freeze F/D.
- `redirect_valid`  out  1  one-cycle pulse, branch taken.
- `redirect_pc`  out  DW  target when `redirect_valid`.
- `busy`  out  1  FSM not in IDLE.

## Operation
- `ready` = `rs_ready` & (`rt_ready` | op uses rs only). Only BEQ and BNE use rt.
- Flags from the sub-comparator: eq = (rs==rt), eqz = (rs==0), ltz = rs[DW-1].
- taken: BEQ eq; BNE !eq; BLEZ ltz|eqz; BGTZ !ltz&!eqz; BLTZ ltz; BGEZ !ltz. Undefined `br_op` is not-taken.
- States: IDLE, WAIT, RESOLVE.
- IDLE:
  - `req_valid`&`ready`: `req_ack`=1, latch taken and target, go to RESOLVE.
  - `req_valid`&!`ready`: `stall`=1, go to WAIT.
- WAIT:
  - `stall`=1. Operands are re-sampled each cycle; latching happens only when `ready`.
  - `ready`&`req_valid`: `req_ack`=1, `stall`=0, go to RESOLVE.
  - `req_valid`=0: return to IDLE with no ack.
- RESOLVE:
  - `redirect_valid`=latched taken, `redirect_pc`=latched target.
  - A new request in the same cycle is handled exactly as in IDLE (back-to-back supported); otherwise go to IDLE.
- `flush` (highest priority): next state IDLE, registered taken cleared. `redirect_valid` is forced 0 in the flush cycle.
- Reset values: state IDLE; `req_ack`, `stall`, `redirect_valid`, `busy` all 0; `redirect_pc` 0; latched taken 0.

## Timing
- `stall` and `req_ack` are combinational from the current state and inputs.
- `redirect_valid` and `redirect_pc` are registered.
- Latency, ready operands: ack at cycle N, redirect at cycle N+1.
- Latency, operands becoming ready k cycles after request: ack at N+k, redirect at N+k+1.
- Stall duration equals the cycles spent not ready. Stall never asserts in the ack cycle.
- `redirect_valid` is never high for more than one cycle per accepted branch.
- Asynchronous reset mid-WAIT or mid-RESOLVE:
  - All outputs go low immediately.
  - No redirect is emitted after release.

## Configuration
- `BRANCH_STAT_EN` defined:
  - Adds outputs `stat_total` and `stat_taken`, both DW bits, reset 0.
  - `stat_total` increments on every `req_ack`. `stat_taken` increments on every `redirect_valid`.
  - Both wrap modulo 2^DW. Neither increments in a flush cycle.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `branch_pkg`:
  - `br_op` encodings: BEQ=0, BNE=1, BLEZ=2, BGTZ=3, BLTZ=4, BGEZ=5.
  - State encodings: IDLE=0, WAIT=1, RESOLVE=2.
  - A helper constant marking rt-using ops.
- One sub-module `br_cmp`:
  - Combinational: eq, eqz, ltz from rs/rt.
  - Instantiated once; the FSM and taken decode live in `branch_sched`.

## Test plan
- BEQ, rs=rt=0x1234, both ready -> `req_ack` at cycle 0; `redirect_valid`=1 with `redirect_pc`=`target` at cycle 1; `stall` never asserts.
- BNE, rs=5, rt=5, ready -> ack at cycle 0; `redirect_valid` stays 0.
- BGTZ, rs=0x80000000 -> not taken. BLEZ, rs=0 -> taken. BGEZ, rs=0 -> taken. BLTZ, rs=0xFFFFFFFF -> taken.
- BEQ with `rt_ready`=0 for 3 cycles -> `stall`=1 for cycles 0-2; ack at cycle 3; redirect at cycle 4. `rt_val` changes while waiting, and the final value decides taken.
- Back-to-back: BGEZ taken, then BLTZ taken in the RESOLVE cycle -> two consecutive one-cycle redirect pulses with the correct targets.
- `flush` in the RESOLVE cycle of a taken BEQ -> no redirect; `busy`=0 next cycle. With `BRANCH_STAT_EN`: `stat_total`=1, `stat_taken`=0.
- Reset asserted mid-WAIT -> `stall`, `busy` and `redirect_valid` drop asynchronously and stay 0 after release.
